fc_layer_seq: RTL and testbench

//  Parametrised single fully-connected layer engine; successor to the fixed FC top-level.

---
 rtl/fc_layer_seq_pkg.sv | 43 ++++
 rtl/fc_layer_seq_if.sv | 34 +++
 rtl/fc_layer_seq_mac.sv | 40 ++++
 rtl/fc_layer_seq.sv | 135 +++++++++++++
 tb/tb_fc_layer_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_layer_seq_pkg.sv
// Shared defaults, FSM encoding and fixed-point helpers for the fully-connected layer engine.
// Helpers work on a 64-bit signed carrier, so accumulators wider than 64 bits are not supported.
package fc_layer_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } fc_state_t;

    // Enough headroom that IN_CELL full-scale products can never overflow.
    function automatic int acc_w(input int data_w, input int in_cell);
        return 2 * data_w + $clog2(in_cell);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                    input int data_w,
                                                    input bit relu);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            r = hi;
        else if (v < lo)
            r = lo;
        else
            r = v;
        if (relu && (r < 64'sd0))
            r = 64'sd0;
        return r;
    endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// Loader write ports, start/status and result stream of the fully-connected layer engine.
interface fc_layer_seq_if #(
    parameter int DATA_W = 16
) ();

    logic              flat_we;
    logic [15:0]       flat_addr;
    logic [DATA_W-1:0] flat_value;
    logic              w_we;
    logic [15:0]       w_addr;
    logic [DATA_W-1:0] w_value;
    logic              start;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       out_addr;
    logic              load_err;

    modport master (
        output flat_we, flat_addr, flat_value,
        output w_we, w_addr, w_value,
        output start,
        input  busy, done, out_valid, out_data, out_addr, load_err
    );

    modport slave (
        input  flat_we, flat_addr, flat_value,
        input  w_we, w_addr, w_value,
        input  start,
        output busy, done, out_valid, out_data, out_addr, load_err
    );

endinterface

// File: rtl/fc_layer_seq_mac.sv
// Signed multiply-accumulate with clear, plus the shift / saturate / optional ReLU output stage.
module fc_layer_seq_mac
    import fc_layer_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int IN_CELL = 14,
    parameter bit RELU    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic        [DATA_W-1:0] result
);

    localparam int ACC_W = acc_w(DATA_W, IN_CELL);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_sh;

    assign prod = (2*DATA_W)'(x) * (2*DATA_W)'(w);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

    // Arithmetic shift truncates toward -inf, matching the Q-format drop of FRAC_W bits.
    assign acc_sh = acc >>> FRAC_W;
    assign result = DATA_W'(sat_relu(64'(acc_sh), DATA_W, RELU));

endmodule

// File: rtl/fc_layer_seq.sv
// Fully-connected layer engine: owns input/weight buffers, arbitrates loader writes, sequences the MAC.
//   state  | meaning
//   IDLE   | waiting for start; loader writes accepted
//   MAC    | acc += x[i]*w[j*IN_CELL+i], one input per cycle
//   OUT    | emit neuron j result, clear acc, next neuron or finish
//   DONE   | one-cycle done pulse, drop busy
module fc_layer_seq
    import fc_layer_seq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int IN_CELL  = 14,
    parameter int OUT_CELL = 10,
    parameter bit RELU     = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    fc_layer_seq_if.slave  bus
);

    localparam int I_W  = idx_w(IN_CELL);
    localparam int J_W  = idx_w(OUT_CELL);
    localparam int W_N  = IN_CELL * OUT_CELL;
    localparam int WA_W = idx_w(W_N);

    fc_state_t         state;
    logic [I_W-1:0]    i;
    logic [J_W-1:0]    j;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       out_addr;
    logic              load_err;

    logic signed [DATA_W-1:0] flat_buf [IN_CELL];
    logic signed [DATA_W-1:0] w_buf    [W_N];

    logic              flat_ok;
    logic              w_ok;
    logic [WA_W-1:0]   w_idx;
    logic              mac_en;
    logic              mac_clr;
    logic [DATA_W-1:0] mac_res;

    // The buffers belong to the sequencer whenever it is not idle.
    assign flat_ok = bus.flat_we && (state == S_IDLE) && (bus.flat_addr < 16'(IN_CELL));
    assign w_ok    = bus.w_we && (state == S_IDLE) && (bus.w_addr < 16'(W_N));

    always_ff @(posedge clk) begin
        if (flat_ok)
            flat_buf[bus.flat_addr[I_W-1:0]] <= bus.flat_value;
        if (w_ok)
            w_buf[bus.w_addr[WA_W-1:0]] <= bus.w_value;
    end

    assign w_idx   = WA_W'(j) * WA_W'(IN_CELL) + WA_W'(i);
    assign mac_en  = (state == S_MAC);
    assign mac_clr = (state != S_MAC);

    fc_layer_seq_mac #(
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .IN_CELL (IN_CELL),
        .RELU    (RELU)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clr),
        .en     (mac_en),
        .x      (flat_buf[i]),
        .w      (w_buf[w_idx]),
        .result (mac_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            i         <= '0;
            j         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            load_err  <= 1'b0;
        end else begin
            done      <= 1'b0;
            out_valid <= 1'b0;
            load_err  <= (bus.flat_we && !flat_ok) || (bus.w_we && !w_ok);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_MAC;
                        i     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (i == I_W'(IN_CELL - 1))
                        state <= S_OUT;
                    else
                        i <= i + I_W'(1);
                end
                S_OUT: begin
                    out_valid <= 1'b1;
                    out_addr  <= 16'(j);
                    out_data  <= mac_res;
                    i         <= '0;
                    if (j == J_W'(OUT_CELL - 1)) begin
                        state <= S_DONE;
                    end else begin
                        j     <= j + J_W'(1);
                        state <= S_MAC;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_addr  = out_addr;
    assign bus.load_err  = load_err;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: ReLU and pass-through instances share stimulus and are checked every cycle
// against a dot-product model of the layer, with directed literal checks pinning that model.
module tb_fc_layer_seq;

    localparam int IN  = 4;
    localparam int OUT = 2;
    localparam int FR  = 8;
    localparam int LAT = IN + 1;
    localparam int DONE_CYC = OUT * LAT + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fc_layer_seq_if #(.DATA_W(16)) a ();
    fc_layer_seq_if #(.DATA_W(16)) b ();

    assign b.flat_we    = a.flat_we;
    assign b.flat_addr  = a.flat_addr;
    assign b.flat_value = a.flat_value;
    assign b.w_we       = a.w_we;
    assign b.w_addr     = a.w_addr;
    assign b.w_value    = a.w_value;
    assign b.start      = a.start;

    fc_layer_seq #(.DATA_W(16), .FRAC_W(FR), .IN_CELL(IN), .OUT_CELL(OUT), .RELU(1'b1))
        dut_r (.clk(clk), .reset(rst), .bus(a));
    fc_layer_seq #(.DATA_W(16), .FRAC_W(FR), .IN_CELL(IN), .OUT_CELL(OUT), .RELU(1'b0))
        dut_n (.clk(clk), .reset(rst), .bus(b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic signed [15:0] x_m [IN];
    logic signed [15:0] w_m [IN*OUT];
    logic        m_running = 1'b0;
    int          m_cyc = 0;
    logic        e_busy = 1'b0, e_done = 1'b0, e_ov = 1'b0, e_lerr = 1'b0;
    logic [15:0] e_addr = '0, e_data_r = '0, e_data_n = '0;

    function automatic logic [15:0] neuron(input int jn, input bit relu);
        longint s;
        s = 0;
        for (int k = 0; k < IN; k++)
            s = s + longint'(x_m[k]) * longint'(w_m[jn*IN + k]);
        s = s >>> FR;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_running <= 1'b0;
            m_cyc     <= 0;
            e_busy    <= 1'b0;
            e_done    <= 1'b0;
            e_ov      <= 1'b0;
            e_lerr    <= 1'b0;
            e_addr    <= '0;
            e_data_r  <= '0;
            e_data_n  <= '0;
        end else begin
            e_lerr <= (a.flat_we && (m_running || a.flat_addr >= 16'(IN))) ||
                      (a.w_we && (m_running || a.w_addr >= 16'(IN*OUT)));
            if (a.flat_we && !m_running && a.flat_addr < 16'(IN))
                x_m[a.flat_addr[1:0]] <= a.flat_value;
            if (a.w_we && !m_running && a.w_addr < 16'(IN*OUT))
                w_m[a.w_addr[2:0]] <= a.w_value;
            e_ov   <= 1'b0;
            e_done <= 1'b0;
            if (m_running) begin
                m_cyc <= m_cyc + 1;
                if (((m_cyc + 1) % LAT == 0) && (m_cyc + 1 <= OUT*LAT)) begin
                    e_ov     <= 1'b1;
                    e_addr   <= 16'((m_cyc + 1) / LAT - 1);
                    e_data_r <= neuron((m_cyc + 1) / LAT - 1, 1'b1);
                    e_data_n <= neuron((m_cyc + 1) / LAT - 1, 1'b0);
                end
                if (m_cyc + 1 == DONE_CYC) begin
                    e_done    <= 1'b1;
                    e_busy    <= 1'b0;
                    m_running <= 1'b0;
                end
            end else if (a.start) begin
                m_running <= 1'b1;
                m_cyc     <= 0;
                e_busy    <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",       32'(a.busy),      32'(e_busy));
            chk("done",       32'(a.done),      32'(e_done));
            chk("out_valid",  32'(a.out_valid), 32'(e_ov));
            chk("load_err",   32'(a.load_err),  32'(e_lerr));
            chk("out_addr",   32'(a.out_addr),  32'(e_addr));
            chk("data_relu",  32'(a.out_data),  32'(e_data_r));
            chk("data_pass",  32'(b.out_data),  32'(e_data_n));
            chk("done_pass",  32'(b.done),      32'(e_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [15:0] tx [IN];
    logic [15:0] tw [IN*OUT];
    int          done_k, ov_k, ndone, write_at, extra_start_at;
    logic        lerr_seen;
    logic [15:0] cap_r [OUT];
    logic [15:0] cap_n [OUT];

    task automatic load_buf();
        for (int k = 0; k < IN*OUT; k++) begin
            @(negedge clk);
            a.flat_we    = (k < IN);
            a.flat_addr  = 16'(k % IN);
            a.flat_value = tx[k % IN];
            a.w_we       = 1'b1;
            a.w_addr     = 16'(k);
            a.w_value    = tw[k];
        end
        @(negedge clk);
        a.flat_we = 1'b0;
        a.w_we    = 1'b0;
    endtask

    task automatic run_layer();
        done_k = -1; ov_k = -1; ndone = 0; lerr_seen = 1'b0;
        @(negedge clk);
        a.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            if (a.out_valid) begin
                if (ov_k < 0) ov_k = k;
                cap_r[a.out_addr[0]] = a.out_data;
                cap_n[b.out_addr[0]] = b.out_data;
            end
            if (a.done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (k == write_at + 1) lerr_seen = a.load_err;
            a.start      = (k == extra_start_at);
            a.flat_we    = (k == write_at);
            a.flat_addr  = 16'd0;
            a.flat_value = 16'h1234;
            @(negedge clk);
        end
        a.start   = 1'b0;
        a.flat_we = 1'b0;
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 2))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 2047)) - 16'd1024;
            default: return ($urandom_range(0, 1) != 0) ? 16'h7F00 : 16'h8100;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a.flat_we = 0; a.flat_addr = 0; a.flat_value = 0;
        a.w_we = 0; a.w_addr = 0; a.w_value = 0; a.start = 0;
        write_at = -10; extra_start_at = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",      32'(a.busy), 0);
        chk("rst_out_valid", 32'(a.out_valid), 0);
        chk("rst_done",      32'(a.done), 0);
        chk("rst_out_data",  32'(a.out_data), 0);
        chk("rst_out_addr",  32'(a.out_addr), 0);
        chk("rst_load_err",  32'(a.load_err), 0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // basic dot product and sign handling
        tx = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
        tw = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        load_buf();
        @(negedge clk);
        chk("model_t1_n0", 32'(neuron(0, 1'b0)), 32'h0280);
        chk("model_t2_n1", 32'(neuron(1, 1'b0)), 32'hFD80);
        chk("model_t2_r1", 32'(neuron(1, 1'b1)), 32'h0000);
        run_layer();
        chk("t1_first_valid", 32'(ov_k), 32'(LAT));
        chk("t1_done_lat",    32'(done_k), 32'(DONE_CYC));
        chk("t1_data",        32'(cap_r[0]), 32'h0280);
        chk("t2_relu",        32'(cap_r[1]), 32'h0000);
        chk("t2_pass",        32'(cap_n[1]), 32'hFD80);

        // saturation
        tx = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
        tw = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h8100, 16'h8100, 16'h8100, 16'h8100};
        load_buf();
        run_layer();
        chk("t3_sat_pos",  32'(cap_n[0]), 32'h7FFF);
        chk("t3_sat_neg",  32'(cap_n[1]), 32'h8000);
        chk("t3_sat_relu", 32'(cap_r[1]), 32'h0000);

        // busy lockout: write to x[0] while the MAC runs is dropped
        tx = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
        tw = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        load_buf();
        write_at = 2;
        run_layer();
        write_at = -10;
        chk("t4_lerr",   32'(lerr_seen), 1);
        chk("t4_result", 32'(cap_n[0]), 32'h0280);

        // out-of-range addresses that would alias x[0] / w[0]
        @(negedge clk);
        a.flat_we = 1; a.flat_addr = 16'd4; a.flat_value = 16'h7777;
        a.w_we = 1;    a.w_addr = 16'd8;    a.w_value = 16'h7777;
        @(negedge clk);
        a.flat_we = 0; a.w_we = 0;
        chk("t5_range_lerr", 32'(a.load_err), 1);
        extra_start_at = 3;
        run_layer();
        extra_start_at = -1;
        chk("t5_one_done", 32'(ndone), 1);
        chk("t5_result",   32'(cap_n[0]), 32'h0280);
        chk("t5_result1",  32'(cap_n[1]), 32'hFD80);

        // reset in the middle of a run
        @(negedge clk);
        a.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a.start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_busy",  32'(a.busy), 0);
        chk("t6_valid", 32'(a.out_valid), 0);
        chk("t6_done",  32'(a.done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_layer();
        chk("t6_rerun",    32'(cap_n[0]), 32'h0280);
        chk("t6_done_lat", 32'(done_k), 32'(DONE_CYC));

        // randomized loads, runs, and interference while busy
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                a.flat_we    = ($urandom_range(0, 1) != 0);
                a.flat_addr  = 16'($urandom_range(0, 5));
                a.flat_value = rnd_val();
                a.w_we       = ($urandom_range(0, 1) != 0);
                a.w_addr     = 16'($urandom_range(0, 9));
                a.w_value    = rnd_val();
            end
            @(negedge clk);
            a.flat_we = 0; a.w_we = 0;
            a.start = 1'b1;
            for (int k = 0; k < 14; k++) begin
                @(negedge clk);
                a.start      = ($urandom_range(0, 9) == 0);
                a.flat_we    = ($urandom_range(0, 3) == 0);
                a.flat_addr  = 16'($urandom_range(0, 5));
                a.flat_value = rnd_val();
                a.w_we       = ($urandom_range(0, 3) == 0);
                a.w_addr     = 16'($urandom_range(0, 9));
                a.w_value    = rnd_val();
            end
            @(negedge clk);
            a.start = 0; a.flat_we = 0; a.w_we = 0;
            for (int t = 0; t < 60 && m_running; t++)
                @(negedge clk);
            chk("rand_run_ends", 32'(m_running), 0);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
